// File: rtl/id_stage.sv
// Purpose : MIPS decode stage - IF/ID register, 32x32 register file with M/W bypass, branch/jump resolution.
// Latency : IF/ID captures on posedge; RD1/RD2 and Branch/J/Jr/Offset/A are combinational from Instr_D.
// Backpressure: Stall holds IF/ID and suppresses redirects; register-file writes proceed regardless.
//
// Ports:
//   Clk, Reset (sync, active-high)
//   Instr_F/PC_F      : fetched instruction and its PC, captured into Instr_D/PC_D
//   Stall             : hold IF/ID, force Branch/J/Jr low
//   WE_W/A3_W/WD_W    : write-back port (also bypassed same cycle)
//   FwdEn_M/FwdA_M/FwdD_M : M-stage forwarding (beats W bypass)
//   RD1/RD2           : forwarded rs/rt values
//   Branch/Offset/J/Index_D/Jr/A : next-PC controls returned to fetch
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr_F,
    input  logic [31:0] PC_F,
    input  logic        Stall,
    input  logic        WE_W,
    input  logic [4:0]  A3_W,
    input  logic [31:0] WD_W,
    input  logic        FwdEn_M,
    input  logic [4:0]  FwdA_M,
    input  logic [31:0] FwdD_M,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        Branch,
    output logic [31:0] Offset,
    output logic        J,
    output logic [25:0] Index_D,
    output logic        Jr,
    output logic [31:0] A
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    // IF/ID register next-state: hold while stalled.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (!Stall) begin
            instr_d = Instr_F;
            pc_d    = PC_F;
        end
    end

    // Register file next-state; $0 is never written.
    always_comb begin
        rf_d = rf_q;
        if (WE_W && (A3_W != 5'd0)) begin
            rf_d[A3_W] = WD_W;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_q <= 32'd0;
            pc_q    <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            rf_q    <= rf_d;
        end
    end

    // Operand read with priority: $0, then M forward, then same-cycle W write, then array.
    function automatic logic [31:0] read_fwd(
        input logic [4:0]  r,
        input logic [31:0] rf_val,
        input logic        fwd_en,
        input logic [4:0]  fwd_a,
        input logic [31:0] fwd_d,
        input logic        we_w,
        input logic [4:0]  a3_w,
        input logic [31:0] wd_w
    );
        logic [31:0] v;
        if (r == 5'd0)                     v = 32'd0;
        else if (fwd_en && (fwd_a == r))   v = fwd_d;
        else if (we_w && (a3_w == r))      v = wd_w;
        else                               v = rf_val;
        return v;
    endfunction

    logic [4:0] rs, rt;
    logic [5:0] op, funct;

    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign op    = instr_q[31:26];
    assign funct = instr_q[5:0];

    always_comb begin
        RD1 = read_fwd(rs, rf_q[rs], FwdEn_M, FwdA_M, FwdD_M, WE_W, A3_W, WD_W);
        RD2 = read_fwd(rt, rf_q[rt], FwdEn_M, FwdA_M, FwdD_M, WE_W, A3_W, WD_W);
    end

    // Redirects are suppressed while stalled so a stale operand never steers fetch;
    // the decision is re-evaluated on the first unstalled cycle.
    always_comb begin
        Branch = 1'b0;
        J      = 1'b0;
        Jr     = 1'b0;
        unique case (op)
            OP_BEQ:   Branch = (RD1 == RD2);
            OP_BNE:   Branch = (RD1 != RD2);
            OP_J,
            OP_JAL:   J      = 1'b1;
            OP_RTYPE: Jr     = (funct == FN_JR);
            default:  ;
        endcase
        if (Stall) begin
            Branch = 1'b0;
            J      = 1'b0;
            Jr     = 1'b0;
        end
    end

    assign Instr_D = instr_q;
    assign PC_D    = pc_q;
    assign Offset  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign Index_D = instr_q[25:0];
    assign A       = RD1;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr_F, PC_F;
    logic        Stall;
    logic        WE_W;
    logic [4:0]  A3_W;
    logic [31:0] WD_W;
    logic        FwdEn_M;
    logic [4:0]  FwdA_M;
    logic [31:0] FwdD_M;
    logic [31:0] Instr_D, PC_D, RD1, RD2, Offset, A;
    logic        Branch, J, Jr;
    logic [25:0] Index_D;

    int tests_run = 0;
    int tests_failed = 0;

    id_stage #(.RESET_PC(32'h00003000)) dut (
        .Clk(Clk), .Reset(Reset), .Instr_F(Instr_F), .PC_F(PC_F), .Stall(Stall),
        .WE_W(WE_W), .A3_W(A3_W), .WD_W(WD_W),
        .FwdEn_M(FwdEn_M), .FwdA_M(FwdA_M), .FwdD_M(FwdD_M),
        .Instr_D(Instr_D), .PC_D(PC_D), .RD1(RD1), .RD2(RD2),
        .Branch(Branch), .Offset(Offset), .J(J), .Index_D(Index_D),
        .Jr(Jr), .A(A)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are changed 1 time unit after posedge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WE_W = 1'b1; A3_W = a; WD_W = d;
        tick();
        WE_W = 1'b0; A3_W = 5'd0; WD_W = 32'd0;
    endtask

    task automatic load(input logic [31:0] instr, input logic [31:0] pc);
        Instr_F = instr; PC_F = pc;
        tick();
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Instr_F = 32'h0; PC_F = 32'h0;
        WE_W = 1'b0; A3_W = 5'd0; WD_W = 32'd0;
        FwdEn_M = 1'b0; FwdA_M = 5'd0; FwdD_M = 32'd0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        chk("rst_instr", Instr_D, 32'h0);
        chk("rst_pc", PC_D, 32'h00003000);
        chk("rst_rd1", RD1, 32'h0);
        chk("rst_rd2", RD2, 32'h0);
        chk("rst_ctl", {29'd0, Branch, J, Jr}, 32'h0);

        // Same-cycle W bypass on rs=5, then registered value.
        load(32'h00A00000, 32'h00003004);
        chk("load_pc", PC_D, 32'h00003004);
        WE_W = 1'b1; A3_W = 5'd5; WD_W = 32'h1234;
        #1;
        chk("bypass_w", RD1, 32'h1234);
        tick();
        WE_W = 1'b0; A3_W = 5'd0; WD_W = 32'd0;
        #1;
        chk("rf_read5", RD1, 32'h1234);

        // Writes to $0 are discarded, also not bypassed.
        load(32'h00000000, 32'h00003008);
        WE_W = 1'b1; A3_W = 5'd0; WD_W = 32'hFFFF;
        #1;
        chk("r0_bypass", RD1, 32'h0);
        tick();
        WE_W = 1'b0;
        #1;
        chk("r0_rd1", RD1, 32'h0);
        chk("r0_rd2", RD2, 32'h0);

        // beq $1,$2,-4 with M forwarding of $2.
        wr(5'd1, 32'd7);
        wr(5'd2, 32'd3);
        load(32'h1022FFFC, 32'h0000300C);
        FwdEn_M = 1'b1; FwdA_M = 5'd2; FwdD_M = 32'd7;
        #1;
        chk("beq_fwd_rd2", RD2, 32'd7);
        chk("beq_taken", {31'd0, Branch}, 32'd1);
        chk("beq_offset", Offset, 32'hFFFFFFF0);
        WE_W = 1'b1; A3_W = 5'd2; WD_W = 32'd9;
        #1;
        chk("m_beats_w", RD2, 32'd7);
        WE_W = 1'b0; A3_W = 5'd0; WD_W = 32'd0;
        FwdEn_M = 1'b0;
        #1;
        chk("beq_nofwd_rd2", RD2, 32'd3);
        chk("beq_not_taken", {31'd0, Branch}, 32'd0);

        // jr $31 held by stall.
        wr(5'd31, 32'h3010);
        load(32'h03E00008, 32'h00003010);
        Stall = 1'b1;
        Instr_F = 32'h12345678; PC_F = 32'h0000BEEC;
        #1;
        chk("stall_jr0", {31'd0, Jr}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", Instr_D, 32'h03E00008);
            chk("stall_pc", PC_D, 32'h00003010);
            chk("stall_jr", {31'd0, Jr}, 32'd0);
        end
        Stall = 1'b0;
        #1;
        chk("jr_after_stall", {31'd0, Jr}, 32'd1);
        chk("jr_target", A, 32'h3010);

        // jal decode.
        load(32'h0C000C05, 32'h00003014);
        chk("jal_j", {31'd0, J}, 32'd1);
        chk("jal_index", {6'd0, Index_D}, 32'h00000C05);
        chk("jal_br_jr", {30'd0, Branch, Jr}, 32'd0);

        // bne equal / unequal.
        load(32'h14210003, 32'h00003018);
        chk("bne_equal", {31'd0, Branch}, 32'd0);
        chk("bne_offset", Offset, 32'h0000000C);
        load(32'h14220003, 32'h0000301C);
        chk("bne_unequal", {31'd0, Branch}, 32'd1);

        // Reset during stall with a taken beq pending.
        load(32'h10210001, 32'h00003020);
        chk("pend_beq", {31'd0, Branch}, 32'd1);
        Stall = 1'b1; Reset = 1'b1;
        tick();
        Stall = 1'b0; Reset = 1'b0;
        #1;
        chk("rststall_instr", Instr_D, 32'h0);
        chk("rststall_pc", PC_D, 32'h00003000);
        chk("rststall_ctl", {29'd0, Branch, J, Jr}, 32'h0);
        chk("rststall_rd", RD1 | RD2, 32'h0);

        // Register file contents cleared by reset.
        load(32'h03E10000, 32'h00003024);
        chk("rf_cleared_31", RD1, 32'h0);
        chk("rf_cleared_1", RD2, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
